// File: rtl/mcu_seq.sv
// Instruction sequencer for the accumulator MCU: fetch/operand handshakes,
// data-memory access, program counter and register-bank strobes.
module mcu_seq #(
    parameter int ADDR_WIDTH = 8,
    parameter int INST_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_ack,
    input  logic [INST_WIDTH-1:0] imem_rdata,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [ADDR_WIDTH-1:0] dmem_addr,
    input  logic                  dmem_ack,
    input  logic [INST_WIDTH-1:0] opcode,
    input  logic [3:0]            psr,
    output logic                  opcode_update,
    output logic                  imem_update,
    output logic                  dmem_update,
    output logic                  psr_update,
    output logic                  res_update,
    output logic [1:0]            res_sel,
    output logic [1:0]            opa_sel,
    output logic [1:0]            opb_sel,
    output logic [3:0]            alu_op,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic                  halted
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_OPND   = 3'd2;
    localparam logic [2:0] S_DMRD   = 3'd3;
    localparam logic [2:0] S_DMWR   = 3'd4;
    localparam logic [2:0] S_EXEC   = 3'd5;
    localparam logic [2:0] S_HALT   = 3'd6;

    localparam logic [1:0] RES_ALU  = 2'd0;
    localparam logic [1:0] RES_DMEM = 2'd1;
    localparam logic [1:0] RES_IMEM = 2'd2;

    localparam logic [1:0] REG_ACC  = 2'd0;
    localparam logic [1:0] REG_IMEM = 2'd1;
    localparam logic [1:0] REG_DMEM = 2'd2;

    localparam logic [ADDR_WIDTH-1:0] PC_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    logic [2:0]            state, state_n;
    logic [ADDR_WIDTH-1:0] pc_q, pc_n, pc_inc, jmp_tgt;
    logic [ADDR_WIDTH-1:0] addr_latch;
    logic                  imem_req_q, dmem_req_q;
    logic                  i_acc, d_acc;
    logic [1:0]            cls;
    logic                  is_ctl, is_jmp, is_jz, is_nop, is_halt, sub_zero;
    logic                  take;
    logic                  unused_ok;

    assign cls      = opcode[7:6];
    assign is_ctl   = (cls == 2'b11);
    assign is_jmp   = is_ctl && (opcode[5:4] == 2'b00);
    assign is_jz    = is_ctl && (opcode[5:4] == 2'b01);
    assign is_nop   = is_ctl && (opcode[5:4] == 2'b10);
    assign is_halt  = is_ctl && (opcode[5:4] == 2'b11);
    assign sub_zero = (opcode[3:0] == 4'd0);
    assign take     = is_jmp || (is_jz && psr[0]);

    // An ack only counts while our own request is outstanding.
    assign i_acc = imem_req_q && imem_ack;
    assign d_acc = dmem_req_q && dmem_ack;

    assign pc_inc  = pc_q + PC_ONE;
    assign jmp_tgt = imem_rdata[ADDR_WIDTH-1:0];

    assign imem_req  = imem_req_q;
    assign imem_addr = pc_q;
    assign dmem_req  = dmem_req_q;
    assign dmem_we   = dmem_req_q && (state == S_DMWR);
    assign dmem_addr = addr_latch;
    assign alu_op    = opcode[3:0];
    assign pc        = pc_q;
    assign halted    = (state == S_HALT);
    assign unused_ok = ^psr[3:1];

    always_comb begin
        state_n       = state;
        pc_n          = pc_q;
        opcode_update = 1'b0;
        imem_update   = 1'b0;
        dmem_update   = 1'b0;
        psr_update    = 1'b0;
        res_update    = 1'b0;
        res_sel       = RES_ALU;
        opa_sel       = REG_ACC;
        opb_sel       = REG_IMEM;
        unique case (state)
            S_FETCH: begin
                if (i_acc) begin
                    opcode_update = 1'b1;
                    pc_n          = pc_inc;
                    state_n       = S_DECODE;
                end
            end
            S_DECODE: begin
                if (is_nop)
                    state_n = S_FETCH;
                else if (is_halt)
                    state_n = S_HALT;
                else
                    state_n = S_OPND;
            end
            S_OPND: begin
                if (i_acc) begin
                    imem_update = 1'b1;
                    if (take) begin
                        pc_n    = jmp_tgt;
                        state_n = S_FETCH;
                    end else begin
                        pc_n = pc_inc;
                        unique case (cls)
                            2'b00:   state_n = S_EXEC;
                            2'b01:   state_n = S_DMRD;
                            2'b10:   state_n = S_DMWR;
                            default: state_n = S_FETCH;
                        endcase
                    end
                end
            end
            S_DMRD: begin
                if (d_acc) begin
                    dmem_update = 1'b1;
                    if (sub_zero) begin
                        res_update = 1'b1;
                        res_sel    = RES_DMEM;
                        state_n    = S_FETCH;
                    end else begin
                        state_n = S_EXEC;
                    end
                end
            end
            S_DMWR: begin
                opa_sel = REG_ACC;
                if (d_acc)
                    state_n = S_FETCH;
            end
            S_EXEC: begin
                res_update = 1'b1;
                state_n    = S_FETCH;
                if (cls == 2'b00 && sub_zero) begin
                    res_sel = RES_IMEM;
                end else begin
                    psr_update = 1'b1;
                    opa_sel    = REG_ACC;
                    opb_sel    = (cls == 2'b01) ? REG_DMEM : REG_IMEM;
                end
            end
            S_HALT: state_n = S_HALT;
            default: state_n = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_FETCH;
            pc_q       <= '0;
            addr_latch <= '0;
            imem_req_q <= 1'b0;
            dmem_req_q <= 1'b0;
        end else begin
            state <= state_n;
            pc_q  <= pc_n;
            if (state == S_OPND && i_acc)
                addr_latch <= jmp_tgt;
            // Requests are raised on entry to a bus state and dropped on ack.
            imem_req_q <= (state_n == S_FETCH) || (state_n == S_OPND);
            dmem_req_q <= (state_n == S_DMRD) || (state_n == S_DMWR);
        end
    end

endmodule
